prim_lambdalib_ram_1p_banked: RTL and testbench

Parametrised single-port RAM primitive built from `NumBanks` lambdalib `la_spram` leaves. It adds a grant/valid handshake, per-group write masking via `DataBitsPerMask`, an optional output register, and a post-reset zero-initialisation sequencer. It sits behind the `prim_ram_1p` abstraction for SRAMs that exceed one macro or need deterministic contents after reset.

---
 rtl/prim_ram_1p_pkg.sv | 36 +++
 rtl/prim_lambdalib_ram_1p_banked_la_spram.sv | 37 +++
 rtl/prim_lambdalib_ram_1p_banked.sv | 200 ++++++++++++++++++++
 tb/tb_prim_lambdalib_ram_1p_banked.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_ram_1p_pkg.sv
// Shared definitions for the single-port RAM wrappers.
// Contents:
//   RamMaxWidth      - widest data word the mask helper can expand
//   ram_init_state_e - post-reset sequencer states (INIT, READY)
//   ram_1p_cfg_t     - macro configuration bundle, carried through to the leaves
//   expand_wmask     - widens a per-group write mask to a per-bit mask
package prim_ram_1p_pkg;

    localparam int RamMaxWidth = 256;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_init_state_e;

    typedef struct packed {
        logic       rme;
        logic [3:0] rm;
        logic       test;
    } ram_1p_cfg_t;

    // Bit i of the result copies mask bit (i / bits_per_mask), so each mask
    // bit covers one contiguous group of data bits.
    function automatic logic [RamMaxWidth-1:0] expand_wmask(
        input logic [RamMaxWidth-1:0] mask,
        input int unsigned            bits_per_mask
    );
        logic [RamMaxWidth-1:0] res;
        res = '0;
        for (int i = 0; i < RamMaxWidth; i++) begin
            res[i] = mask[i / bits_per_mask];
        end
        return res;
    endfunction

endpackage

// File: rtl/prim_lambdalib_ram_1p_banked_la_spram.sv
// Behavioural single-port SRAM leaf with the lambdalib la_spram port shape.
// Ports:
//   clk   - clock
//   ce    - chip enable; nothing happens without it
//   we    - 1 = write, 0 = read
//   wmask - per-bit write enable
//   addr  - row address
//   din   - write data
//   dout  - read data, updated one edge after a read and held otherwise
module la_spram #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic [DW-1:0] wmask,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    // Writes merge under the bit mask; only reads move dout, so a write
    // issued after a read leaves the returned word untouched.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/prim_lambdalib_ram_1p_banked.sv
// Banked single-port RAM built from NumBanks la_spram leaves.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   req_i/gnt_o  - request and grant; an access is taken when both are high
//   write_i      - 1 = write, 0 = read
//   addr_i       - word address; addresses at or above Depth are accepted
//                  but writes are dropped and reads return zero
//   wdata_i      - write data
//   wmask_i      - one bit per DataBitsPerMask-bit group of the data word
//   rdata_o      - read data, meaningful while rvalid_o is high
//   rvalid_o     - one pulse per accepted read
//   init_done_o  - array is ready for traffic
//   cfg_i        - macro configuration, not used by the behavioural leaves
module prim_lambdalib_ram_1p_banked
    import prim_ram_1p_pkg::*;
#(
    parameter int Width           = 32,
    parameter int Depth           = 1024,
    parameter int NumBanks        = 2,
    parameter int DataBitsPerMask = 1,
    parameter int OutputReg       = 0,
    parameter int InitZero        = 1,
    localparam int Aw        = $clog2(Depth),
    localparam int Bw        = $clog2(NumBanks),
    localparam int BankDepth = Depth / NumBanks,
    localparam int Mw        = Width / DataBitsPerMask
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             write_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Mw-1:0]    wmask_i,
    output logic [Width-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             init_done_o,
    input  ram_1p_cfg_t      cfg_i
);

    // Bank and row fields keep at least one bit so single-bank or
    // single-row builds still elaborate.
    localparam int BwS = (Bw > 0) ? Bw : 1;
    localparam int Rw  = $clog2(BankDepth);
    localparam int RwS = (Rw > 0) ? Rw : 1;

    if (Depth % NumBanks != 0) begin : gen_chk_depth
        $error("Depth must be a multiple of NumBanks");
    end
    if (Width % DataBitsPerMask != 0) begin : gen_chk_width
        $error("Width must be a multiple of DataBitsPerMask");
    end
    if (NumBanks < 1 || (NumBanks & (NumBanks - 1)) != 0) begin : gen_chk_banks
        $error("NumBanks must be a power of two");
    end
    if (Width > RamMaxWidth) begin : gen_chk_maxw
        $error("Width exceeds RamMaxWidth");
    end

    ram_init_state_e  state;
    logic [RwS-1:0]   init_row;
    logic             in_init;
    logic             accept;

    logic [Aw:0]      addr_ext;
    logic [Aw:0]      quot;
    logic [Aw:0]      rem;
    logic [BwS-1:0]   bank_sel;
    logic [RwS-1:0]   row_sel;
    logic             oor;

    logic [RamMaxWidth-1:0] wmask_ext;
    logic [Width-1:0]       wmask_full;

    logic             bank_we;
    logic [RwS-1:0]   bank_row;
    logic [Width-1:0] bank_din;
    logic [Width-1:0] bank_wmask;
    logic [Width-1:0] bank_dout [NumBanks];

    logic             rd_pending;
    logic [BwS-1:0]   rd_bank;
    logic             rd_oor;
    logic [Width-1:0] rdata_mux;

    logic             unused_bits;

    assign in_init = (state == INIT);
    assign accept  = req_i & gnt_o;

    // One extra address bit keeps Depth and BankDepth representable for
    // the range check and the divide, whatever their values.
    assign addr_ext = {1'b0, addr_i};
    assign quot     = addr_ext / (Aw+1)'(BankDepth);
    assign rem      = addr_ext % (Aw+1)'(BankDepth);
    assign bank_sel = quot[BwS-1:0];
    assign row_sel  = rem[RwS-1:0];
    assign oor      = addr_ext >= (Aw+1)'(Depth);

    assign wmask_ext  = expand_wmask(RamMaxWidth'(wmask_i), DataBitsPerMask);
    assign wmask_full = wmask_ext[Width-1:0];

    assign unused_bits = ^{cfg_i, quot, rem, wmask_ext};

    // Sequencer: sweeps every row of all banks with zeros, then grants.
    // gnt_o and init_done_o follow the state one edge later, so they depend
    // on state only and never on req_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= (InitZero != 0) ? INIT : READY;
            init_row    <= '0;
            gnt_o       <= 1'b0;
            init_done_o <= 1'b0;
        end else begin
            gnt_o       <= (state == READY);
            init_done_o <= (state == READY);
            case (state)
                INIT: begin
                    if (init_row == RwS'(BankDepth - 1)) begin
                        state <= READY;
                    end else begin
                        init_row <= init_row + RwS'(1);
                    end
                end
                READY: state <= READY;
                default: state <= READY;
            endcase
        end
    end

    // Leaf inputs are shared; only chip enable is per bank.
    always_comb begin
        bank_we    = in_init | write_i;
        bank_row   = in_init ? init_row : row_sel;
        bank_din   = in_init ? '0 : wdata_i;
        bank_wmask = in_init ? '1 : wmask_full;
    end

    for (genvar b = 0; b < NumBanks; b++) begin : gen_bank
        logic bank_ce;
        assign bank_ce = in_init | (accept & ~oor & (bank_sel == BwS'(b)));

        la_spram #(
            .DW (Width),
            .AW (RwS)
        ) u_spram (
            .clk   (clk_i),
            .ce    (bank_ce),
            .we    (bank_we),
            .wmask (bank_wmask),
            .addr  (bank_row),
            .din   (bank_din),
            .dout  (bank_dout[b])
        );
    end

    // Bank select and range flag travel with the read so the return mux
    // never looks at the address of a later access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pending <= 1'b0;
            rd_bank    <= '0;
            rd_oor     <= 1'b0;
        end else begin
            rd_pending <= accept & ~write_i;
            if (accept & ~write_i) begin
                rd_bank <= bank_sel;
                rd_oor  <= oor;
            end
        end
    end

    always_comb begin
        rdata_mux = '0;
        if (!rd_oor) begin
            for (int b = 0; b < NumBanks; b++) begin
                if (rd_bank == BwS'(b)) begin
                    rdata_mux = bank_dout[b];
                end
            end
        end
    end

    if (OutputReg != 0) begin : gen_out_reg
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rdata_o  <= '0;
                rvalid_o <= 1'b0;
            end else begin
                rdata_o  <= rdata_mux;
                rvalid_o <= rd_pending;
            end
        end
    end else begin : gen_out_comb
        assign rdata_o  = rdata_mux;
        assign rvalid_o = rd_pending;
    end

endmodule

// File: tb/tb_prim_lambdalib_ram_1p_banked.sv
// Self-checking bench for prim_lambdalib_ram_1p_banked. Two instances share
// one stimulus stream: dut_a (Depth 768, OutputReg 0) and dut_b (Depth 1024,
// OutputReg 1), both with two banks and byte masks. A flat-array model holds
// the expected contents of each.
module tb_prim_lambdalib_ram_1p_banked;
    import prim_ram_1p_pkg::*;

    localparam int DepthA = 768;
    localparam int DepthB = 1024;

    logic        clk;
    logic        rst;
    logic        req;
    logic        write;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    ram_1p_cfg_t cfg;

    logic        gnt_a, rvalid_a, init_done_a;
    logic [31:0] rdata_a;
    logic        gnt_b, rvalid_b, init_done_b;
    logic [31:0] rdata_b;

    int pass_count = 0;
    int check_count = 0;
    int cyc = 0;
    bit chk_on = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mem_a [DepthA];
    logic [31:0] mem_b [DepthB];

    prim_lambdalib_ram_1p_banked #(
        .Width(32), .Depth(DepthA), .NumBanks(2), .DataBitsPerMask(8),
        .OutputReg(0), .InitZero(1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_a),
        .write_i(write), .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
        .rdata_o(rdata_a), .rvalid_o(rvalid_a), .init_done_o(init_done_a),
        .cfg_i(cfg)
    );

    prim_lambdalib_ram_1p_banked #(
        .Width(32), .Depth(DepthB), .NumBanks(2), .DataBitsPerMask(8),
        .OutputReg(1), .InitZero(1)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_b),
        .write_i(write), .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
        .rdata_o(rdata_b), .rvalid_o(rvalid_b), .init_done_o(init_done_b),
        .cfg_i(cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rq, input logic wr, input logic [9:0] ad,
                                 input logic [31:0] wd, input logic [3:0] wm);
        @(negedge clk);
        req   = rq;
        write = wr;
        addr  = ad;
        wdata = wd;
        wmask = wm;
    endtask

    task automatic resetModel();
        for (int i = 0; i < DepthA; i++) mem_a[i] = '0;
        for (int i = 0; i < DepthB; i++) mem_b[i] = '0;
        qa.delete();
        qb.delete();
    endtask

    // Counts edges after reset release until gnt/init_done first read high.
    task automatic measureInit(input int exp_a, input int exp_b);
        int ka, kb, da, db;
        ka = 0; kb = 0; da = 0; db = 0;
        for (int k = 1; k <= 1200; k++) begin
            @(posedge clk);
            #1;
            if (ka == 0 && gnt_a) ka = k;
            if (kb == 0 && gnt_b) kb = k;
            if (da == 0 && init_done_a) da = k;
            if (db == 0 && init_done_b) db = k;
            if (ka != 0 && kb != 0 && da != 0 && db != 0) break;
        end
        checkOutput("init_gnt_a_edges", 32'(ka), 32'(exp_a));
        checkOutput("init_gnt_b_edges", 32'(kb), 32'(exp_b));
        checkOutput("init_done_a_edges", 32'(da), 32'(exp_a));
        checkOutput("init_done_b_edges", 32'(db), 32'(exp_b));
    endtask

    // Reference model: plain arrays updated on every accepted access.
    always @(posedge clk) begin
        logic [31:0] bitmask;
        cyc++;
        if (chk_on && !rst && req) begin
            bitmask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
            if (write) begin
                if (int'(addr) < DepthA)
                    mem_a[addr] = (mem_a[addr] & ~bitmask) | (wdata & bitmask);
                mem_b[addr] = (mem_b[addr] & ~bitmask) | (wdata & bitmask);
            end else begin
                qa.push_back('{cyc, (int'(addr) < DepthA) ? mem_a[addr] : 32'h0});
                qb.push_back('{cyc + 1, mem_b[addr]});
            end
        end
    end

    // Every cycle: rvalid must match the model's schedule, and data must
    // match when it is due.
    always @(negedge clk) begin
        if (chk_on) begin
            if (qa.size() > 0 && qa[0].cyc == cyc) begin
                checkOutput("rvalid_a", 32'(rvalid_a), 32'd1);
                checkOutput("rdata_a", rdata_a, qa[0].data);
                void'(qa.pop_front());
            end else begin
                checkOutput("rvalid_a_idle", 32'(rvalid_a), 32'd0);
            end
            if (qb.size() > 0 && qb[0].cyc == cyc) begin
                checkOutput("rvalid_b", 32'(rvalid_b), 32'd1);
                checkOutput("rdata_b", rdata_b, qb[0].data);
                void'(qb.pop_front());
            end else begin
                checkOutput("rvalid_b_idle", 32'(rvalid_b), 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
    endtask

    initial begin
        logic [9:0] pool [12];
        logic [9:0] ad;

        pool = '{10'd0, 10'd32, 10'd383, 10'd384, 10'd416, 10'd511,
                 10'd512, 10'd767, 10'd768, 10'd800, 10'd1023, 10'd100};
        rst = 1'b1; req = 1'b0; write = 1'b0; addr = '0; wdata = '0; wmask = '0;
        cfg = '0;
        resetModel();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_gnt_a", 32'(gnt_a), 32'd0);
        checkOutput("reset_gnt_b", 32'(gnt_b), 32'd0);
        checkOutput("reset_rvalid_a", 32'(rvalid_a), 32'd0);
        checkOutput("reset_rvalid_b", 32'(rvalid_b), 32'd0);
        checkOutput("reset_done_a", 32'(init_done_a), 32'd0);
        checkOutput("reset_done_b", 32'(init_done_b), 32'd0);
        checkOutput("reset_rdata_b", rdata_b, 32'd0);
        rst = 1'b0;
        measureInit(DepthA / 2 + 1, DepthB / 2 + 1);

        @(negedge clk);
        chk_on = 1'b1;
        // Zeroed contents, including the bank boundary and the top word.
        applyStimulus(1'b1, 1'b0, 10'd0, 32'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 10'd511, 32'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 10'd512, 32'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 10'd1023, 32'd0, 4'd0);
        idle(2);
        // Bank crossing, back-to-back reads.
        applyStimulus(1'b1, 1'b1, 10'd511, 32'hDEADBEEF, 4'hF);
        applyStimulus(1'b1, 1'b1, 10'd512, 32'h12345678, 4'hF);
        applyStimulus(1'b1, 1'b0, 10'd511, 32'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 10'd512, 32'd0, 4'd0);
        // Partial write over a zero word.
        applyStimulus(1'b1, 1'b1, 10'd100, 32'hFFFFFFFF, 4'b0101);
        applyStimulus(1'b1, 1'b0, 10'd100, 32'd0, 4'd0);
        // Write following a read must not disturb the returning word.
        applyStimulus(1'b1, 1'b1, 10'd100, 32'h0BADF00D, 4'hF);
        // Out of range for dut_a; its alias rows must stay intact.
        applyStimulus(1'b1, 1'b1, 10'd800, 32'hAAAA5555, 4'hF);
        applyStimulus(1'b1, 1'b0, 10'd800, 32'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 10'd32, 32'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 10'd416, 32'd0, 4'd0);
        idle(3);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 1) == 0) ad = 10'($urandom_range(0, 1023));
            else ad = pool[$urandom_range(0, 11)];
            applyStimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), ad,
                          $urandom, 4'($urandom));
        end
        idle(5);
        checkOutput("drain_a", 32'(qa.size()), 32'd0);
        checkOutput("drain_b", 32'(qb.size()), 32'd0);
        chk_on = 1'b0;

        // Reset right after a read is accepted: no pulse may follow.
        applyStimulus(1'b1, 1'b0, 10'd5, 32'd0, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("kill_rvalid_a", 32'(rvalid_a), 32'd0);
            checkOutput("kill_rvalid_b", 32'(rvalid_b), 32'd0);
        end
        resetModel();
        rst = 1'b0;

        // Reset in the middle of initialisation restarts from row 0.
        repeat (300) @(posedge clk);
        #1;
        checkOutput("midinit_done_b", 32'(init_done_b), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        measureInit(DepthA / 2 + 1, DepthB / 2 + 1);

        @(negedge clk);
        chk_on = 1'b1;
        applyStimulus(1'b1, 1'b0, 10'd511, 32'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 10'd100, 32'd0, 4'd0);
        idle(4);
        chk_on = 1'b0;
        checkOutput("final_drain_a", 32'(qa.size()), 32'd0);
        checkOutput("final_drain_b", 32'(qb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
